vga_timing_sequencer: RTL
=========================

// Module: vga_timing_sequencer
// PURPOSE
//  Owns VGA frame timing: generates column/row counters, porch-aware HSync/VSync and
//  active-video flag, and sequences pixel fetch from the upstream pixel source with a
//  one-cycle lookahead request. Sits between the UART-driven control logic (enable)
//  and the DAC/pin outputs; replaces free-running counters plus combinational porch decode.
// PARAMETERS
//  H_ACTIVE 640 | H_FRONT 18 | H_SYNC 92 | H_BACK 50  horizontal phases in clocks (total 800)
//  V_ACTIVE 480 | V_FRONT 10 | V_SYNC 2  | V_BACK 33  vertical phases in lines (total 525)
//  PIX_W    3   pixel word width (RGB)
// PORTS
//  CLK         in   1      pixel clock
//  RST         in   1      asynchronous, active-high reset
//  i_Enable    in   1      run request; level-sensitive
//  i_PixData   in   PIX_W  pixel for last request
//  i_PixValid  in   1      i_PixData valid (must return the cycle after o_PixReq)
//  o_PixReq    out  1      pixel fetch request, one cycle ahead of display
//  o_PixCol    out  10     column of requested pixel
//  o_PixRow    out  10     row of requested pixel
//  o_CountCol  out  10     current column 0..799
//  o_CountRow  out  10     current row 0..524
//  o_HSync     out  1      active-low
//  o_VSync     out  1      active-low
//  o_Active    out  1      current (col,row) inside 640x480
//  o_Pixel     out  PIX_W  displayed pixel; 0 outside active or on underrun
//  o_FrameStart out 1      one-cycle pulse at col 0,row 0
//  o_Underrun  out  1      sticky; set when o_PixReq not answered by i_PixValid
// BEHAVIOUR
//  - All outputs registered. Reset: counters 0, o_HSync=o_VSync=1, all others 0; FSM=IDLE.
//  - Top FSM: IDLE -> RUN when i_Enable=1 (first RUN cycle is col 0,row 0, o_FrameStart=1).
//    RUN -> DRAIN when i_Enable drops; DRAIN completes the frame through col 799,row 524,
//    then IDLE. i_Enable re-asserted in DRAIN -> back to RUN, no frame break.
//    In IDLE counters hold 0, syncs 1, o_Active/o_PixReq 0.
//  - Horizontal phase FSM: H_ACT(0..639) -> H_FP(640..657) -> H_SYN(658..749) -> H_BP(750..799)
//    -> wrap to 0. Row advances on col 799 wrap; vertical FSM V_ACT(0..479) -> V_FP(480..489)
//    -> V_SYN(490..491) -> V_BP(492..524) -> wrap 0.
//  - o_HSync=0 exactly in H_SYN; o_VSync=0 exactly in V_SYN (row-based, full lines).
//  - o_Active = H_ACT && V_ACT. o_PixReq asserted the cycle before each active pixel
//    (incl. col 799 of row r preceding row r+1 col 0, and row 524 -> row 0).
//  - Latency: request cycle N -> i_PixData sampled N+1 -> o_Pixel valid N+1 with o_Active.
//  - Underrun: o_Active=1 and i_PixValid=0 -> o_Pixel=0, o_Underrun set; cleared on o_FrameStart
//    unless another underrun occurs that same cycle (set wins).
//  - Reset mid-frame: immediate IDLE, all outputs to reset values; no partial-frame resume.
//  - Counter widths 10 bits; parameter totals must be <= 1024 (elaboration check).
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: adds input i_PatternSel; when 1, o_Pixel = 8 vertical colour
//   bars (o_Pixel = o_CountCol/80, truncated to PIX_W), o_PixReq forced 0, underrun never set.
//  Undefined: port absent, o_Pixel always from i_PixData path.
// STRUCTURE
//  vga_timing_defs.vh: default timing constants, FSM state encodings (IDLE/RUN/DRAIN,
//   ACT/FP/SYN/BP), shared with other VGA blocks.
//  Sub-module vga_axis_counter (instantiated H and V): count, advance enable, wrap pulse,
//   phase output; parameterised by the four phase lengths.
// TESTING
//  1 Reset then i_Enable=1: first frame o_FrameStart at col 0,row 0; next at exactly 420000 clks.
//  2 Check o_HSync low cols 658..749 only, o_VSync low rows 490..491 only, every line/frame.
//  3 Pixel source echoes {row[0],col[1:0]} with i_PixValid=1: o_Pixel matches at every active
//    (col,row), 0 elsewhere; o_PixReq count per frame = 307200.
//  4 Drop i_PixValid at row 10 col 100: o_Pixel=0 that cycle, o_Underrun=1 until next FrameStart.
//  5 Deassert i_Enable at row 200: frame completes to col 799,row 524 then IDLE; re-assert in
//    DRAIN at row 300: no gap, next FrameStart on schedule.
//  6 Assert RST at row 250 col 400: same cycle syncs=1, counters 0; with VGA_TEST_PATTERN_EN,
//    i_PatternSel=1 gives bar value 3 at col 240..319 and o_PixReq=0.

Source files
------------

// File: rtl/vga_timing_sequencer_pkg.sv
// ============================================================================
// Module : vga_timing_sequencer_pkg
// Brief  : Shared VGA timing types, counter width and phase-decode helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_sequencer_pkg;

    localparam int                 CNT_W   = 10;
    localparam int                 CNT_LIM = 1 << CNT_W;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } axis_phase_t;

    // Back-porch length is implied: anything past active+front+sync is BP.
    function automatic axis_phase_t axis_phase(
        input logic [CNT_W-1:0] cnt,
        input int               act_len,
        input int               front_len,
        input int               sync_len
    );
        int c;
        c = int'(cnt);
        if (c < act_len)
            axis_phase = PH_ACT;
        else if (c < act_len + front_len)
            axis_phase = PH_FP;
        else if (c < act_len + front_len + sync_len)
            axis_phase = PH_SYN;
        else
            axis_phase = PH_BP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_sequencer_axis_counter.sv
// ============================================================================
// Module : vga_timing_sequencer_axis_counter
// Brief  : One timing axis (H or V): registered count with advance/clear,
//          next-count lookahead, phase of the next count and end-of-axis flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_sequencer_axis_counter
    import vga_timing_sequencer_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 18,
    parameter int SYNC   = 92,
    parameter int BACK   = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output axis_phase_t      phase_next,
    output logic             last
);

    localparam int               TOTAL    = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    generate
        if (TOTAL > CNT_LIM || TOTAL < 2) begin : g_total_check
            $error("axis total %0d does not fit the %0d-bit counter", TOTAL, CNT_W);
        end
    endgenerate

    always_comb begin
        last = (count == LAST_CNT);
        if (clear)
            count_next = '0;
        else if (advance && last)
            count_next = '0;
        else if (advance)
            count_next = count + CNT_ONE;
        else
            count_next = count;
        phase_next = axis_phase(count_next, ACTIVE, FRONT, SYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_sequencer.sv
// ============================================================================
// Module : vga_timing_sequencer
// Brief  : VGA frame timing with porch-aware syncs and one-cycle lookahead
//          pixel fetch. VGA_TEST_PATTERN_EN adds i_PatternSel colour bars.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_sequencer
    import vga_timing_sequencer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 18,
    parameter int H_SYNC   = 92,
    parameter int H_BACK   = 50,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int PIX_W    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_Enable,
    input  logic [PIX_W-1:0] i_PixData,
    input  logic             i_PixValid,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             i_PatternSel,
`endif
    output logic             o_PixReq,
    output logic [CNT_W-1:0] o_PixCol,
    output logic [CNT_W-1:0] o_PixRow,
    output logic [CNT_W-1:0] o_CountCol,
    output logic [CNT_W-1:0] o_CountRow,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Active,
    output logic [PIX_W-1:0] o_Pixel,
    output logic             o_FrameStart,
    output logic             o_Underrun
);

    localparam int               H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int               V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
`ifdef VGA_TEST_PATTERN_EN
    localparam int               BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
`endif

    seq_state_t       state;
    seq_state_t       state_next;
    logic             running;
    logic             running_next;
    logic             clear_cnt;
    logic             row_advance;
    logic             h_last;
    logic             v_last;
    logic [CNT_W-1:0] col_next;
    logic [CNT_W-1:0] row_next;
    axis_phase_t      h_phase_next;
    axis_phase_t      v_phase_next;
    logic [CNT_W-1:0] col_after;
    logic [CNT_W-1:0] row_after;
    logic             act_next;
    logic             req_next;
    logic             fs_next;
    logic             under_set;
    logic             under_next;
    logic [PIX_W-1:0] pix_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= SEQ_IDLE;
        else
            state <= state_next;
    end

    // Stopping is only allowed once the last pixel of the frame is on screen.
    always_comb begin
        state_next = state;
        case (state)
            SEQ_IDLE:  if (i_Enable) state_next = SEQ_RUN;
            SEQ_RUN:   if (!i_Enable) state_next = (h_last && v_last) ? SEQ_IDLE : SEQ_DRAIN;
            SEQ_DRAIN: begin
                if (i_Enable)
                    state_next = SEQ_RUN;
                else if (h_last && v_last)
                    state_next = SEQ_IDLE;
            end
            default:   state_next = SEQ_IDLE;
        endcase
    end

    assign running      = (state != SEQ_IDLE);
    assign running_next = (state_next != SEQ_IDLE);
    assign clear_cnt    = (state_next == SEQ_IDLE);
    assign row_advance  = running && h_last;

    vga_timing_sequencer_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_counter (
        .clk        (CLK),
        .rst        (RST),
        .clear      (clear_cnt),
        .advance    (running),
        .count      (o_CountCol),
        .count_next (col_next),
        .phase_next (h_phase_next),
        .last       (h_last)
    );

    vga_timing_sequencer_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_counter (
        .clk        (CLK),
        .rst        (RST),
        .clear      (clear_cnt),
        .advance    (row_advance),
        .count      (o_CountRow),
        .count_next (row_next),
        .phase_next (v_phase_next),
        .last       (v_last)
    );

    // Position following the one about to be displayed: target of the lookahead request.
    always_comb begin
        col_after = col_next + CNT_ONE;
        row_after = row_next;
        if (col_next == H_LAST) begin
            col_after = '0;
            row_after = (row_next == V_LAST) ? '0 : row_next + CNT_ONE;
        end
    end

    always_comb begin
        act_next  = running_next && (h_phase_next == PH_ACT) && (v_phase_next == PH_ACT);
        fs_next   = running_next && (col_next == '0) && (row_next == '0);
        req_next  = running_next
                    && (axis_phase(col_after, H_ACTIVE, H_FRONT, H_SYNC) == PH_ACT)
                    && (axis_phase(row_after, V_ACTIVE, V_FRONT, V_SYNC) == PH_ACT)
                    && !(state_next == SEQ_DRAIN && col_next == H_LAST && row_next == V_LAST);
        pix_next  = '0;
        under_set = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        if (i_PatternSel) begin
            req_next = 1'b0;
            if (act_next)
                pix_next = PIX_W'(col_next / BAR_W);
        end else
`endif
        begin
            if (act_next && i_PixValid)
                pix_next = i_PixData;
            under_set = act_next && !i_PixValid;
        end
        under_next = under_set ? 1'b1 : (fs_next ? 1'b0 : o_Underrun);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_PixReq     <= 1'b0;
            o_PixCol     <= '0;
            o_PixRow     <= '0;
            o_HSync      <= 1'b1;
            o_VSync      <= 1'b1;
            o_Active     <= 1'b0;
            o_Pixel      <= '0;
            o_FrameStart <= 1'b0;
            o_Underrun   <= 1'b0;
        end else begin
            o_PixReq     <= req_next;
            o_PixCol     <= running_next ? col_after : '0;
            o_PixRow     <= running_next ? row_after : '0;
            o_HSync      <= !(running_next && h_phase_next == PH_SYN);
            o_VSync      <= !(running_next && v_phase_next == PH_SYN);
            o_Active     <= act_next;
            o_Pixel      <= pix_next;
            o_FrameStart <= fs_next;
            o_Underrun   <= under_next;
        end
    end

endmodule

`default_nettype wire
